div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits and result width at 64 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; all state is cleared while reset==0 at a rising edge.
REQ-004 start  input  1  divide request from EXE; initiator holds it high until it samples done==1.
REQ-005 flush  input  1  pipeline flush; abandons any in-flight divide.
REQ-006 signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-007 opdata1  input  32  dividend.
REQ-008 opdata2  input  32  divisor.
REQ-009 result  output  64  {remainder[63:32], quotient[31:0]}; registered.
REQ-010 done  output  1  result valid; registered.

Function
REQ-011 The FSM SHALL have four states: IDLE, DIVZERO, ON, END.
REQ-012 IDLE: at an edge with start==1 and flush==0, capture opdata1, opdata2 and signed_div; go to DIVZERO if opdata2==0, else go to ON with iteration counter=0.
REQ-013 Capture SHALL take absolute values when signed_div==1 and the operand is negative; operand inputs changing after capture SHALL NOT affect the result.
REQ-014 ON: perform one restoring shift-subtract step (33-bit partial remainder) per cycle; the counter increments 0..31.
REQ-015 On the edge completing step 31, apply sign correction and register result, then go to END; quotient is negated if signed and sign(dividend)!=sign(divisor); remainder is negated if signed and the dividend is negative.
REQ-016 Latency: if start is sampled at edge E0, done==1 and result are valid after edge E32 (32 edges in ON).
REQ-017 DIVZERO: at the next edge, go to END with result=64'h0.
REQ-018 END: done==1 and result held stable while start==1; at an edge with start==0, go to IDLE with done=0 and result=64'h0.
REQ-019 flush==1 at any edge in DIVZERO, ON or END SHALL force IDLE with done=0 and result=64'h0 and discard the partial state.
REQ-020 flush SHALL have priority over start; in IDLE, start with flush==1 SHALL NOT begin a divide.
REQ-021 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (two's-complement wrap, no exception).
REQ-022 Arithmetic is modulo 2^32 per half; no exceptions or error outputs.
REQ-023 done SHALL never be 1 outside END; a new divide SHALL start only from IDLE.

Reset
REQ-024 While reset==0 at an edge: state=IDLE, counter=0, done=0, result=64'h0, captured operands cleared.
REQ-025 reset SHALL override flush and start, including mid-ON; the first divide after reset release behaves exactly as REQ-012..REQ-018.

Verification
REQ-026 Unsigned: opdata1=100, opdata2=7, signed_div=0, start held -> done rises after edge E32; result={32'd2, 32'd14}; drop start -> done=0 and result=0 at the next edge.
REQ-027 Signed: opdata1=0xFFFFFFF9 (-7), opdata2=2, signed_div=1 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; and 7 / -2 -> quotient=0xFFFFFFFD, remainder=0x00000001.
REQ-028 Divide by zero: opdata2=0 with any opdata1 -> done after edge E1, result=64'h0.
REQ-029 Flush: assert flush for one cycle at iteration 10 -> IDLE, done never asserts, result=0; a new start with 50/5 then yields {0, 10} after E32.
REQ-030 Overflow and unsigned: 0x80000000 / 0xFFFFFFFF gives signed {0, 0x80000000} and unsigned {0x80000000, 0}; operands changed after E0 do not alter the result.
REQ-031 Reset mid-ON (iteration 20) -> outputs 0 at the next edge; the subsequent divide 9/3 gives {0, 3} with full latency.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit signed/unsigned restoring divider, {remainder, quotient} result
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    output logic [63:0] result,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [31:0] quo, quo_n;
    logic [31:0] rem, rem_n;
    logic [31:0] dvs, dvs_n;
    logic        neg_q, neg_q_n;
    logic        neg_r, neg_r_n;
    logic [63:0] result_n;
    logic        done_n;

    logic [31:0] a_abs, b_abs;
    logic [32:0] shifted, diff;
    logic        fits;
    logic [31:0] step_rem, step_quo;

    // quo starts as the dividend and fills with quotient bits from the right
    always_comb begin
        a_abs    = (signed_div && opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
        b_abs    = (signed_div && opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;
        shifted  = {rem, quo[31]};
        diff     = shifted - {1'b0, dvs};
        fits     = ~diff[32];
        step_rem = fits ? diff[31:0] : shifted[31:0];
        step_quo = {quo[30:0], fits};
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        quo_n    = quo;
        rem_n    = rem;
        dvs_n    = dvs;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        result_n = result;
        done_n   = done;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    quo_n   = a_abs;
                    dvs_n   = b_abs;
                    rem_n   = 32'd0;
                    cnt_n   = 5'd0;
                    neg_q_n = signed_div && (opdata1[31] ^ opdata2[31]);
                    neg_r_n = signed_div && opdata1[31];
                    state_n = (opdata2 == 32'd0) ? DIVZERO : ON;
                end
            end
            DIVZERO: begin
                state_n  = END;
                done_n   = 1'b1;
                result_n = 64'h0;
            end
            ON: begin
                quo_n = step_quo;
                rem_n = step_rem;
                cnt_n = cnt + 5'd1;
                if (cnt == 5'd31) begin
                    result_n[63:32] = neg_r ? (~step_rem + 32'd1) : step_rem;
                    result_n[31:0]  = neg_q ? (~step_quo + 32'd1) : step_quo;
                    done_n          = 1'b1;
                    state_n         = END;
                end
            end
            END: begin
                if (!start) begin
                    state_n  = IDLE;
                    done_n   = 1'b0;
                    result_n = 64'h0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (flush && state != IDLE) begin
            state_n  = IDLE;
            cnt_n    = 5'd0;
            quo_n    = 32'd0;
            rem_n    = 32'd0;
            dvs_n    = 32'd0;
            neg_q_n  = 1'b0;
            neg_r_n  = 1'b0;
            done_n   = 1'b0;
            result_n = 64'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            quo    <= 32'd0;
            rem    <= 32'd0;
            dvs    <= 32'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= 64'h0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            quo    <= quo_n;
            rem    <= rem_n;
            dvs    <= dvs_n;
            neg_q  <= neg_q_n;
            neg_r  <= neg_r_n;
            result <= result_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed vector bench for div_unit
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush, signed_div;
    logic [31:0] opdata1, opdata2;
    logic [63:0] result;
    logic        done;

    int pass_cnt = 0;
    int total_cnt = 0;

    div_unit dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .signed_div(signed_div), .opdata1(opdata1), .opdata2(opdata2),
        .result(result), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // pre > 0 holds flush high alongside start for that many edges first
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp, input int lat, input int pre,
                           input string name);
        int cycles;
        logic [63:0] held;
        @(negedge clk);
        opdata1 = a; opdata2 = b; signed_div = s; start = 1'b1; flush = (pre > 0);
        if (pre > 0) begin
            repeat (pre) @(posedge clk);
            @(negedge clk);
            flush = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        opdata1 = ~a; opdata2 = b + 32'd5; signed_div = ~s;
        cycles = 0;
        while (!done && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        chk({name, "_latency"}, 64'(cycles), 64'(lat));
        chk({name, "_result"}, result, exp);
        held = result;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_hold_done"}, 64'(done), 64'd1);
        chk({name, "_hold_result"}, result, held);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_drop_done"}, 64'(done), 64'd0);
        chk({name, "_drop_result"}, result, 64'h0);
    endtask

    initial begin
        int   cycles;
        logic seen_done;

        vecs[0] = '{32'd100,      32'd7,          1'b0, {32'd2,          32'd14},         32, "u_100_7"};
        vecs[1] = '{32'hFFFFFFF9, 32'd2,          1'b1, {32'hFFFFFFFF,   32'hFFFFFFFD},   32, "s_m7_2"};
        vecs[2] = '{32'd7,        32'hFFFFFFFE,   1'b1, {32'h00000001,   32'hFFFFFFFD},   32, "s_7_m2"};
        vecs[3] = '{32'd12345,    32'd0,          1'b1, 64'h0,                            1,  "divzero"};
        vecs[4] = '{32'h80000000, 32'hFFFFFFFF,   1'b1, {32'h0,          32'h80000000},   32, "s_overflow"};
        vecs[5] = '{32'h80000000, 32'hFFFFFFFF,   1'b0, {32'h80000000,   32'h0},          32, "u_big"};
        vecs[6] = '{32'hFFFFFFFF, 32'd1,          1'b0, {32'h0,          32'hFFFFFFFF},   32, "u_max_1"};
        vecs[7] = '{32'hFFFFFF9C, 32'hFFFFFFF9,   1'b1, {32'hFFFFFFFE,   32'h0000000E},   32, "s_m100_m7"};
        vecs[8] = '{32'd5,        32'd10,         1'b0, {32'd5,          32'd0},          32, "u_5_10"};
        vecs[9] = '{32'hFFFFFFF9, 32'd2,          1'b0, {32'd1,          32'h7FFFFFFC},   32, "u_fff9_2"};

        reset = 1'b0; start = 1'b0; flush = 1'b0; signed_div = 1'b0;
        opdata1 = 32'd0; opdata2 = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", result, 64'h0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++)
            run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, vecs[i].lat, 0, vecs[i].name);

        // flush at iteration 10, then no done for a while
        @(negedge clk);
        opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_on_done", 64'(done), 64'd0);
        chk("flush_on_result", result, 64'h0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("flush_no_done", 64'(seen_done), 64'd0);
        run_div(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 32, 0, "after_flush_50_5");

        // flush while in END with start still held
        @(negedge clk);
        opdata1 = 32'd6; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        cycles = 0;
        while (!done && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        chk("end_reached", 64'(done), 64'd1);
        chk("end_result", result, {32'd0, 32'd2});
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("flush_end_done", 64'(done), 64'd0);
        chk("flush_end_result", result, 64'h0);

        // start masked by flush in IDLE: latency counts from the flush-free edge
        run_div(32'd21, 32'd4, 1'b0, {32'd1, 32'd5}, 32, 2, "flush_prio");

        // reset mid-ON at iteration 20
        @(negedge clk);
        opdata1 = 32'd1000; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_mid_done", 64'(done), 64'd0);
        chk("reset_mid_result", result, 64'h0);
        reset = 1'b1;
        run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 32, 0, "after_reset_9_3");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
